// File: rtl/bcd_pow2_accumulator.sv
// rtl/bcd_pow2_accumulator.sv - digit-serial BCD accumulator of power-of-two weights
//
// Consumes one binary bit per step, LSB first. A BCD power register walks
// 1,2,4,8,... and every accepted '1' bit adds the current power into a BCD
// accumulator. Each step processes one BCD digit per clock.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   start       clears acc/pow/flags and aborts any step in progress
//   step_valid  a bit is offered on step_bit
//   step_bit    binary bit of the current weight
//   step_last   marks step_bit as the final (MSB) bit
//   step_ready  block can accept a step this cycle
//   bcd_out     accumulator digits, [0] = units
//   done        1-cycle pulse when the last step completes
//   overflow    sticky; result exceeds numberOfDigits digits

module bcd_pow2_accumulator #(
    parameter int numberOfDigits = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           step_valid,
    input  logic                           step_bit,
    input  logic                           step_last,
    output logic                           step_ready,
    output logic [numberOfDigits-1:0][3:0] bcd_out,
    output logic                           done,
    output logic                           overflow
);

    localparam int idxWidth = (numberOfDigits > 1) ? $clog2(numberOfDigits) : 1;
    localparam logic [idxWidth-1:0] LAST_IDX = idxWidth'(numberOfDigits - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                           state;
    logic [numberOfDigits-1:0][3:0]   acc;
    logic [numberOfDigits-1:0][3:0]   pow;
    logic [idxWidth-1:0]              idx;
    logic                             c_add;
    logic                             c_dbl;
    logic                             bit_r;
    logic                             last_r;
    // Set once the power register itself has carried out of the top digit;
    // from then on any '1' bit adds a wrong weight.
    logic                             pow_wrap;

    logic [4:0] sum;
    logic [4:0] dbl;
    logic       add_carry;
    logic       dbl_carry;
    logic [3:0] add_digit;
    logic [3:0] dbl_digit;

    // Per-digit add and doubling; both read the pre-doubling pow digit.
    always_comb begin
        sum       = 5'(acc[idx]) + (bit_r ? 5'(pow[idx]) : 5'd0) + 5'(c_add);
        dbl       = {pow[idx], 1'b0} + 5'(c_dbl);
        add_carry = (sum > 5'd9);
        dbl_carry = (dbl > 5'd9);
        add_digit = add_carry ? 4'(sum - 5'd10) : sum[3:0];
        dbl_digit = dbl_carry ? 4'(dbl - 5'd10) : dbl[3:0];
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            state    <= IDLE;
            acc      <= '0;
            pow      <= '0;
            pow[0]   <= 4'd1;
            idx      <= '0;
            c_add    <= 1'b0;
            c_dbl    <= 1'b0;
            bit_r    <= 1'b0;
            last_r   <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            pow_wrap <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (step_valid) begin
                        bit_r  <= step_bit;
                        last_r <= step_last;
                        idx    <= '0;
                        c_add  <= 1'b0;
                        c_dbl  <= 1'b0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    acc[idx] <= add_digit;
                    pow[idx] <= dbl_digit;
                    c_add    <= add_carry;
                    c_dbl    <= dbl_carry;
                    if (idx == LAST_IDX) begin
                        overflow <= overflow | add_carry | (bit_r & pow_wrap);
                        pow_wrap <= pow_wrap | dbl_carry;
                        done     <= last_r;
                        state    <= IDLE;
                    end else begin
                        idx <= idx + idxWidth'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign step_ready = (state == IDLE);
    assign bcd_out    = acc;

endmodule

// File: tb/tb_bcd_pow2_accumulator.sv
// tb/tb_bcd_pow2_accumulator.sv - self-checking bench for bcd_pow2_accumulator

module tb_bcd_pow2_accumulator;

    localparam int N = 3;
    localparam int MODV = 1000;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             step_valid;
    logic             step_bit;
    logic             step_last;
    logic             step_ready;
    logic [N-1:0][3:0] bcd_out;
    logic             done;
    logic             overflow;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int busy_wait = 0;

    // Reference model state: plain integers modulo 10^N.
    int m_acc, m_pow;
    bit m_wrap, m_ovf;

    typedef struct {
        int           nbits;
        logic [15:0]  pattern;
        int           exp_val;
        bit           exp_ovf;
    } vec_t;

    vec_t vecs[7];

    bcd_pow2_accumulator #(.numberOfDigits(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .step_valid (step_valid),
        .step_bit   (step_bit),
        .step_last  (step_last),
        .step_ready (step_ready),
        .bcd_out    (bcd_out),
        .done       (done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    function automatic int bcd_val(input logic [N-1:0][3:0] d);
        int v = 0;
        for (int i = N - 1; i >= 0; i--) v = v * 10 + int'(d[i]);
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_start();
        m_acc = 0; m_pow = 1; m_wrap = 0; m_ovf = 0;
    endtask

    task automatic model_step(input bit b);
        if (b) begin
            if (m_acc + m_pow >= MODV || m_wrap) m_ovf = 1;
            m_acc = (m_acc + m_pow) % MODV;
        end
        if (2 * m_pow >= MODV) m_wrap = 1;
        m_pow = (2 * m_pow) % MODV;
    endtask

    // Called at a negedge; returns at a negedge after start was sampled.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0;
    endtask

    // Offers a bit (valid stays high) and returns at the negedge just after acceptance.
    task automatic send(input bit b, input bit l);
        int cnt = 0;
        step_valid = 1'b1;
        step_bit   = b;
        step_last  = l;
        while (!step_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        busy_wait = cnt;
        if (cnt >= 20) check("ready_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic finish_step();
        int cnt = 0;
        step_valid = 1'b0;
        while (!step_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 20) check("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; step_valid = 1'b0; step_bit = 1'b0; step_last = 1'b0;
        vecs[0] = '{3,  16'b101,        5,   1'b0};
        vecs[1] = '{8,  16'hFF,         255, 1'b0};
        vecs[2] = '{10, 16'h3FF,        23,  1'b1};
        vecs[3] = '{9,  16'h1FF,        511, 1'b0};
        vecs[4] = '{9,  16'h100,        256, 1'b0};
        vecs[5] = '{10, 16'd999,        999, 1'b0};
        vecs[6] = '{10, 16'd1000,       0,   1'b1};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_bcd", bcd_val(bcd_out), 0);
        check("reset_ready", int'(step_ready), 1);
        check("reset_done", int'(done), 0);
        check("reset_ovf", int'(overflow), 0);

        // Table vectors, step_valid held between bits
        foreach (vecs[v]) begin
            pulse_start();
            for (int i = 0; i < vecs[v].nbits; i++)
                send(vecs[v].pattern[i], i == vecs[v].nbits - 1);
            check($sformatf("vec%0d_busy_cycles", v), busy_wait, 3);
            finish_step();
            check($sformatf("vec%0d_bcd", v), bcd_val(bcd_out), vecs[v].exp_val);
            check($sformatf("vec%0d_ovf", v), int'(overflow), int'(vecs[v].exp_ovf));
            check($sformatf("vec%0d_done", v), done_cnt, 1);
        end

        // Random sequences against the model, checked after every step
        for (int r = 0; r < 20; r++) begin
            int nb;
            nb = $urandom_range(1, 14);
            pulse_start();
            model_start();
            for (int i = 0; i < nb; i++) begin
                bit b;
                b = 1'($urandom_range(0, 1));
                send(b, i == nb - 1);
                finish_step();
                model_step(b);
                check($sformatf("rnd%0d_s%0d_bcd", r, i), bcd_val(bcd_out), m_acc);
                check($sformatf("rnd%0d_s%0d_ovf", r, i), int'(overflow), int'(m_ovf));
            end
            check($sformatf("rnd%0d_done", r), done_cnt, 1);
        end

        // Start in the 2nd BUSY cycle aborts a '1' step
        pulse_start();
        send(1'b1, 1'b1);
        step_valid = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_ready", int'(step_ready), 1);
        check("abort_bcd", bcd_val(bcd_out), 0);
        repeat (4) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        send(1'b1, 1'b1);
        finish_step();
        check("after_abort_bcd", bcd_val(bcd_out), 1);
        check("after_abort_done", done_cnt, 1);

        // Accumulation continues past a done pulse without start
        send(1'b1, 1'b1);
        finish_step();
        check("post_done_bcd", bcd_val(bcd_out), 3);

        // rst mid-BUSY with acc=007
        pulse_start();
        for (int i = 0; i < 3; i++) send(1'b1, 1'b0);
        finish_step();
        check("pre_rst_bcd", bcd_val(bcd_out), 7);
        send(1'b1, 1'b0);
        step_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_bcd", bcd_val(bcd_out), 0);
        check("rst_ready", int'(step_ready), 1);
        check("rst_done", int'(done), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_no_done", done_cnt, 0);

        // start and step_valid together: step ignored
        start = 1'b1; step_valid = 1'b1; step_bit = 1'b1; step_last = 1'b1;
        @(negedge clk);
        start = 1'b0; step_valid = 1'b0;
        check("start_prio_ready", int'(step_ready), 1);
        repeat (5) @(negedge clk);
        check("start_prio_bcd", bcd_val(bcd_out), 0);
        check("start_prio_no_done", done_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
